// File: rtl/vga_sync_receiver.sv
// ---------------------------------------------------------------------------
// vga_sync_receiver
//
// Sink end of the board's VGA timing interface. Registers HSync, VSync and
// the 9-bit beam colour, recovers the beam column/row from the sync edges,
// checks that every line and frame has the expected timing, and reports lock.
// While locked it captures the colour at one probe coordinate once per frame.
//
// Ports
//   i_Clk          pixel clock
//   i_Rst_L        asynchronous reset, active low
//   i_HSync        horizontal sync, active low
//   i_VSync        vertical sync, active low
//   i_Rgb          {R[2:0],G[2:0],B[2:0]} beam colour
//   i_Probe_Col    column to sample
//   i_Probe_Row    row to sample
//   o_Column       recovered column of the pixel held in the input register
//   o_Row          recovered row of that pixel
//   o_Active       pixel is on screen and timing is locked
//   o_Locked       timing locked
//   o_Frame_Start  1-cycle pulse when the counters wrap to (0,0) while locked
//   o_Line_Err     1-cycle pulse, HSync edge at an unexpected column
//   o_Frame_Err    1-cycle pulse, VSync fall at an unexpected row
//   o_Probe_Color  last captured probe colour (held)
//   o_Probe_Valid  1-cycle pulse when o_Probe_Color is updated
//   o_Frame_Count  number of locked frames seen, wraps 255 -> 0
// ---------------------------------------------------------------------------
module vga_sync_receiver #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FPORCH    = 16,
    parameter int H_PULSE     = 96,
    parameter int H_MAX       = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_FPORCH    = 10,
    parameter int V_MAX       = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_HSync,
    input  logic       i_VSync,
    input  logic [8:0] i_Rgb,
    input  logic [9:0] i_Probe_Col,
    input  logic [9:0] i_Probe_Row,
    output logic [9:0] o_Column,
    output logic [9:0] o_Row,
    output logic       o_Active,
    output logic       o_Locked,
    output logic       o_Frame_Start,
    output logic       o_Line_Err,
    output logic       o_Frame_Err,
    output logic [8:0] o_Probe_Color,
    output logic       o_Probe_Valid,
    output logic [7:0] o_Frame_Count
);

    localparam logic [9:0]  COL_LAST  = 10'(H_MAX - 1);
    localparam logic [9:0]  COL_FALL  = 10'(H_ACTIVE + H_FPORCH);
    localparam logic [9:0]  COL_LOAD  = 10'(H_ACTIVE + H_FPORCH + 1);
    localparam logic [9:0]  COL_RISE  = 10'(H_ACTIVE + H_FPORCH + H_PULSE);
    localparam logic [9:0]  COL_VIS   = 10'(H_ACTIVE);
    localparam logic [9:0]  ROW_LAST  = 10'(V_MAX - 1);
    localparam logic [9:0]  ROW_VS    = 10'(V_ACTIVE + V_FPORCH - 1);
    localparam logic [9:0]  ROW_VIS   = 10'(V_ACTIVE);
    localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);
    localparam logic [11:0] LOS_LIMIT = 12'(2 * H_MAX);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LINE   = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        hs_q, hs_d, vs_q, vs_d;
    logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [8:0]  rgb_q, rgb_d;
    logic [9:0]  col_q, col_d, row_q, row_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic [11:0] los_cnt_q, los_cnt_d;
    logic        locked_q, locked_d;
    logic        frame_start_q, frame_start_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;
    logic [8:0]  probe_color_q, probe_color_d;
    logic        probe_valid_q, probe_valid_d;
    logic [7:0]  frame_count_q, frame_count_d;

    logic        hs_fall, hs_rise, vs_fall;
    logic        col_wrap, frame_wrap, checking, los, active, probe_hit;
    logic [3:0]  good_inc;

    // Edge detection, wrap detection and error classification.
    // Only CHECK and LOCKED judge the timing; earlier states are still
    // acquiring alignment so their mismatches are expected.
    always_comb begin
        hs_fall    = hs_prev_q & ~hs_q;
        hs_rise    = ~hs_prev_q & hs_q;
        vs_fall    = vs_prev_q & ~vs_q;
        col_wrap   = (col_q == COL_LAST);
        frame_wrap = col_wrap && (row_q == ROW_LAST);
        checking   = (state_q == CHECK) || (state_q == LOCKED);
        line_err_d = checking && ((hs_fall && (col_q != COL_FALL)) ||
                                  (hs_rise && (col_q != COL_RISE)));
        frame_err_d = checking && vs_fall && (row_q != ROW_VS);
        los        = (state_q != SEARCH) && (los_cnt_q == LOS_LIMIT);
        active     = (col_q < COL_VIS) && (row_q < ROW_VIS) && locked_q;
        probe_hit  = active && (col_q == i_Probe_Col) && (row_q == i_Probe_Row);
        good_inc   = good_cnt_q + 4'd1;
    end

    // Beam counters. An HSync fall realigns the column in every state, even
    // when it is the edge that raised a line error, so resync starts at once.
    // A VSync fall realigns the row once a line has been seen, and wins over
    // the row increment from a simultaneous column wrap.
    always_comb begin
        hs_d      = i_HSync;
        vs_d      = i_VSync;
        hs_prev_d = hs_q;
        vs_prev_d = vs_q;
        rgb_d     = i_Rgb;

        col_d = col_wrap ? 10'd0 : col_q + 10'd1;
        if (hs_fall) begin
            col_d = COL_LOAD;
        end

        row_d = row_q;
        if (col_wrap) begin
            row_d = (row_q == ROW_LAST) ? 10'd0 : row_q + 10'd1;
        end
        if (vs_fall && (state_q != SEARCH)) begin
            row_d = ROW_VS;
        end

        // Clocks since the last HSync fall, saturating at the loss limit.
        if (hs_fall) begin
            los_cnt_d = 12'd0;
        end else if (los_cnt_q == LOS_LIMIT) begin
            los_cnt_d = los_cnt_q;
        end else begin
            los_cnt_d = los_cnt_q + 12'd1;
        end
    end

    // Lock FSM: find a line, then a frame, then require LOCK_FRAMES clean
    // frame wraps. Any timing error or a missing HSync sends it back to SEARCH.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        case (state_q)
            SEARCH: begin
                if (hs_fall) begin
                    state_d = LINE;
                end
            end
            LINE: begin
                if (vs_fall) begin
                    state_d    = CHECK;
                    good_cnt_d = 4'd0;
                end
            end
            CHECK: begin
                if (frame_wrap) begin
                    good_cnt_d = good_inc;
                    if (good_inc == LOCK_N) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                state_d = LOCKED;
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
        if (line_err_d || frame_err_d || los) begin
            state_d = SEARCH;
        end
    end

    // Lock status, frame bookkeeping and the probe capture.
    always_comb begin
        locked_d      = (state_d == LOCKED);
        frame_start_d = frame_wrap && locked_q;
        frame_count_d = frame_count_q + {7'd0, frame_start_d};
        probe_valid_d = probe_hit;
        probe_color_d = probe_hit ? rgb_q : probe_color_q;
    end

    // Sync samples reset to the idle-high level so that no phantom edge is
    // seen in the first cycles after reset.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q       <= SEARCH;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            rgb_q         <= 9'd0;
            col_q         <= 10'd0;
            row_q         <= 10'd0;
            good_cnt_q    <= 4'd0;
            los_cnt_q     <= 12'd0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            probe_color_q <= 9'd0;
            probe_valid_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            rgb_q         <= rgb_d;
            col_q         <= col_d;
            row_q         <= row_d;
            good_cnt_q    <= good_cnt_d;
            los_cnt_q     <= los_cnt_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
            probe_color_q <= probe_color_d;
            probe_valid_q <= probe_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign o_Column      = col_q;
    assign o_Row         = row_q;
    assign o_Active      = active;
    assign o_Locked      = locked_q;
    assign o_Frame_Start = frame_start_q;
    assign o_Line_Err    = line_err_q;
    assign o_Frame_Err   = frame_err_q;
    assign o_Probe_Color = probe_color_q;
    assign o_Probe_Valid = probe_valid_q;
    assign o_Frame_Count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_receiver
//
// Drives vga_sync_receiver with a reduced-size raster (16 clocks x 10 lines:
// 8 visible columns, front porch 2, HSync 3 wide; 5 visible rows, VSync low on
// rows 6..7) so that many frames fit in a short run. The generator can shorten
// one line, narrow one HSync pulse, drop one line from a frame or stop HSync.
// Expected event cycles are worked out by hand from that raster; cycle 0 is
// the falling edge at which reset is released and pixel 0 is driven.
// ---------------------------------------------------------------------------
module tb_vga_sync_receiver;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic       i_HSync = 1'b1;
    logic       i_VSync = 1'b1;
    logic [8:0] i_Rgb = 9'd0;
    logic [9:0] i_Probe_Col = 10'd0;
    logic [9:0] i_Probe_Row = 10'd0;
    logic [9:0] o_Column, o_Row;
    logic       o_Active, o_Locked, o_Frame_Start, o_Line_Err, o_Frame_Err;
    logic [8:0] o_Probe_Color;
    logic       o_Probe_Valid;
    logic [7:0] o_Frame_Count;

    vga_sync_receiver #(
        .H_ACTIVE(8), .H_FPORCH(2), .H_PULSE(3), .H_MAX(16),
        .V_ACTIVE(5), .V_FPORCH(2), .V_MAX(10), .LOCK_FRAMES(2)
    ) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_HSync(i_HSync), .i_VSync(i_VSync),
        .i_Rgb(i_Rgb), .i_Probe_Col(i_Probe_Col), .i_Probe_Row(i_Probe_Row),
        .o_Column(o_Column), .o_Row(o_Row), .o_Active(o_Active),
        .o_Locked(o_Locked), .o_Frame_Start(o_Frame_Start),
        .o_Line_Err(o_Line_Err), .o_Frame_Err(o_Frame_Err),
        .o_Probe_Color(o_Probe_Color), .o_Probe_Valid(o_Probe_Valid),
        .o_Frame_Count(o_Frame_Count)
    );

    always #5 i_Clk = ~i_Clk;

    int totalChecks = 0;
    int badChecks = 0;
    int cyc = 0;

    // Generator state and fault knobs (frame numbers, -1 = never).
    int genCol, genRow, genFrame;
    int cutFrame, narrowFrame, shortFrame;
    bit hsKill;
    int pixCol, pixRow;

    // Event monitor.
    int   lockRiseFirst, lockRiseLast, lockFallLast;
    int   lineErrCnt, lineErrFirst, frameErrCnt, frameErrFirst;
    int   fsCnt, fsLast, fsPeriod, pvCnt, pvFirst;
    logic prevLocked;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] req);
        totalChecks++;
        if (act !== req) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, act, req);
        end
    endtask

    task automatic drivePixel();
        int lineLen, pulse, frameLen;
        lineLen  = (genFrame == cutFrame && genRow == 3) ? 15 : 16;
        pulse    = (genFrame == narrowFrame && genRow == 3) ? 2 : 3;
        frameLen = (genFrame == shortFrame) ? 9 : 10;
        i_HSync  = hsKill ? 1'b1 : !(genCol >= 10 && genCol < 10 + pulse);
        i_VSync  = !(genRow >= 6 && genRow < 8);
        i_Rgb    = (genCol == pixCol && genRow == pixRow) ? 9'h1C0 : 9'h000;
        genCol++;
        if (genCol == lineLen) begin
            genCol = 0;
            genRow++;
            if (genRow == frameLen) begin
                genRow = 0;
                genFrame++;
            end
        end
    endtask

    task automatic sampleOutputs();
        if (o_Locked && !prevLocked) begin
            if (lockRiseFirst < 0) lockRiseFirst = cyc;
            lockRiseLast = cyc;
        end
        if (!o_Locked && prevLocked) lockFallLast = cyc;
        prevLocked = o_Locked;
        if (o_Line_Err) begin
            lineErrCnt++;
            if (lineErrFirst < 0) lineErrFirst = cyc;
        end
        if (o_Frame_Err) begin
            frameErrCnt++;
            if (frameErrFirst < 0) frameErrFirst = cyc;
        end
        if (o_Frame_Start) begin
            if (fsCnt == 1) fsPeriod = cyc - fsLast;
            fsLast = cyc;
            fsCnt++;
        end
        if (o_Probe_Valid) begin
            if (pvFirst < 0) pvFirst = cyc;
            pvCnt++;
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(negedge i_Clk);
            cyc++;
            sampleOutputs();
            drivePixel();
        end
    endtask

    task automatic runTo(input int target);
        applyStimulus(target - cyc);
    endtask

    // Assert reset part-way through a high clock phase, optionally check the
    // asynchronous clear, then release at a falling edge with the generator
    // restarted at pixel (0,0).
    task automatic doReset(input bit checkZero);
        @(posedge i_Clk);
        #2;
        i_Rst_L = 1'b0;
        #1;
        if (checkZero) begin
            checkOutput("rst_column", o_Column, 0);
            checkOutput("rst_row", o_Row, 0);
            checkOutput("rst_locked", o_Locked, 0);
            checkOutput("rst_frame_count", o_Frame_Count, 0);
            checkOutput("rst_probe_color", o_Probe_Color, 0);
            checkOutput("rst_pulses", {o_Active, o_Frame_Start, o_Line_Err, o_Frame_Err, o_Probe_Valid}, 0);
        end
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        genCol = 0; genRow = 0; genFrame = 0;
        cutFrame = -1; narrowFrame = -1; shortFrame = -1; hsKill = 1'b0;
        lockRiseFirst = -1; lockRiseLast = -1; lockFallLast = -1;
        lineErrCnt = 0; lineErrFirst = -1; frameErrCnt = 0; frameErrFirst = -1;
        fsCnt = 0; fsLast = -1; fsPeriod = -1; pvCnt = 0; pvFirst = -1;
        prevLocked = 1'b0;
        cyc = 0;
        i_Rst_L = 1'b1;
        drivePixel();
    endtask

    initial begin
        pixCol = 3; pixRow = 2;
        i_Probe_Col = 10'd3; i_Probe_Row = 10'd2;

        // Clean stream with on-screen probe.
        doReset(1'b1);
        runTo(1000);
        checkOutput("clean_lock_cycle", lockRiseFirst, 321);
        checkOutput("clean_frame_starts", fsCnt, 4);
        checkOutput("clean_frame_period", fsPeriod, 160);
        checkOutput("clean_line_errs", lineErrCnt, 0);
        checkOutput("clean_frame_errs", frameErrCnt, 0);
        checkOutput("clean_frame_count", o_Frame_Count, 4);
        checkOutput("clean_column", o_Column, 7);
        checkOutput("clean_row", o_Row, 2);
        checkOutput("clean_active", o_Active, 1);
        checkOutput("probe_first", pvFirst, 357);
        checkOutput("probe_count", pvCnt, 5);
        checkOutput("probe_color", o_Probe_Color, 9'h1C0);

        // Reset mid-line while locked, then relock from scratch.
        doReset(1'b1);
        runTo(400);
        checkOutput("rerst_lock_cycle", lockRiseFirst, 321);

        // One shortened line while locked.
        doReset(1'b0);
        cutFrame = 2;
        runTo(820);
        checkOutput("short_line_err_cycle", lineErrFirst, 395);
        checkOutput("short_line_err_count", lineErrCnt, 1);
        checkOutput("short_line_unlock", lockFallLast, 395);
        checkOutput("short_line_relock", lockRiseLast, 640);
        checkOutput("short_line_frame_errs", frameErrCnt, 0);
        checkOutput("short_line_frame_count", o_Frame_Count, 1);

        // One narrow HSync pulse while locked.
        doReset(1'b0);
        narrowFrame = 2;
        runTo(700);
        checkOutput("narrow_err_cycle", lineErrFirst, 382);
        checkOutput("narrow_err_count", lineErrCnt, 1);
        checkOutput("narrow_unlock", lockFallLast, 382);
        checkOutput("narrow_relock", lockRiseLast, 641);

        // Off-screen probe, then HSync disappears.
        doReset(1'b0);
        pixCol = 12; pixRow = 2;
        i_Probe_Col = 10'd12; i_Probe_Row = 10'd2;
        runTo(600);
        checkOutput("offscreen_probe_count", pvCnt, 0);
        checkOutput("offscreen_probe_color", o_Probe_Color, 0);
        hsKill = 1'b1;
        runTo(700);
        checkOutput("los_unlock", lockFallLast, 621);
        checkOutput("los_line_errs", lineErrCnt, 0);
        checkOutput("los_frame_errs", frameErrCnt, 0);

        // Frame one line short, then run the frame counter through its wrap.
        doReset(1'b0);
        shortFrame = 3;
        runTo(722);
        checkOutput("short_frame_err_cycle", frameErrFirst, 722);
        checkOutput("short_frame_unlock", lockFallLast, 722);
        checkOutput("short_frame_count_at_err", o_Frame_Count, 2);
        runTo(1200);
        checkOutput("short_frame_relock", lockRiseLast, 1105);
        checkOutput("short_frame_count_held", o_Frame_Count, 2);
        checkOutput("short_frame_err_count", frameErrCnt, 1);
        runTo(41744);
        checkOutput("count_before_wrap", o_Frame_Count, 255);
        runTo(41745);
        checkOutput("count_after_wrap", o_Frame_Count, 0);
        checkOutput("wrap_line_errs", lineErrCnt, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
